vga_tile_compositor: RTL and testbench

Parametrised tile-map compositor for the VGA path: turns the timing generator's pixel coordinate into a map tile read plus a sprite read, then merges them with colour-key transparency and a frame-stepped progress-bar overlay. It supersedes the fixed 16×16 / one-player / one-exit frame logic. It sits between the VGA sync generator and the DAC pins, and drives external 1-cycle-latency ROM read ports for the map and the sprites.

---
 rtl/vga_comp_pkg.sv | 18 +
 rtl/vga_bar_fsm.sv | 81 ++++++++
 rtl/vga_tile_compositor.sv | 133 +++++++++++++
 tb/tb_vga_tile_compositor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_comp_pkg.sv
// Shared types and constants for the VGA tile compositor.
package vga_comp_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD
    } bar_state_t;

    localparam logic [11:0] BAR_COLOUR = 12'hF00;

endpackage

// File: rtl/vga_bar_fsm.sv
// Progress-bar sequencer: frame-tick detector, fill level and hold timer.
// Built only when VGA_COMP_BAR_EN is defined.
//   state | meaning
//   IDLE  | level 0, waiting for a start pulse
//   FILL  | level steps up by one per frame tick until BAR_STEPS
//   HOLD  | full bar shown; down-counts frame ticks, then back to IDLE
module vga_bar_fsm
    import vga_comp_pkg::*;
#(
    parameter int BAR_STEPS   = 15,
    parameter int HOLD_FRAMES = 60,
    parameter int LVL_W       = $clog2(BAR_STEPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic [9:0]       col,
    input  logic [9:0]       row,
    input  logic             bar_start,
    output logic             busy,
    output logic [LVL_W-1:0] level
);
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    bar_state_t        state, state_nxt;
    logic [LVL_W-1:0]  level_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic              frame_tick;

    assign frame_tick = pix_valid && (col == 10'd0) && (row == 10'd0);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            level    <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            level    <= level_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        level_nxt    = level;
        hold_cnt_nxt = hold_cnt;
        case (state)
            IDLE: begin
                level_nxt = '0;
                // A start that lands on a frame tick only arms FILL; no increment yet.
                if (bar_start) state_nxt = FILL;
            end
            FILL: begin
                if (frame_tick) begin
                    level_nxt = level + LVL_W'(1);
                    if (level_nxt == LVL_W'(BAR_STEPS)) begin
                        state_nxt    = HOLD;
                        hold_cnt_nxt = HOLD_W'(HOLD_FRAMES - 1);
                    end
                end
            end
            HOLD: begin
                if (frame_tick) begin
                    if (hold_cnt == '0) begin
                        state_nxt = IDLE;
                        level_nxt = '0;
                    end else begin
                        hold_cnt_nxt = hold_cnt - HOLD_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                level_nxt = '0;
            end
        endcase
    end

endmodule

// File: rtl/vga_tile_compositor.sv
// Tile-map + sprite compositor with colour-key transparency, 2-cycle latency.
// Define VGA_COMP_BAR_EN to build the frame-stepped progress-bar overlay.
module vga_tile_compositor
    import vga_comp_pkg::*;
#(
    parameter int          TILE_LOG2   = 4,
    parameter int          MAP_COLS    = 40,
    parameter int          MAP_ROWS    = 30,
    parameter int          NUM_SPRITES = 2,
    parameter logic [11:0] TRANSP_KEY  = 12'hF0F,
    parameter int          BAR_ROW     = 450,
    parameter int          BAR_X0      = 20,
    parameter int          BAR_STEP_W  = 40,
    parameter int          BAR_STEPS   = 15,
    parameter int          HOLD_FRAMES = 60,
    parameter int          MAP_AW      = $clog2(MAP_COLS * MAP_ROWS),
    parameter int          SPR_AW      = $clog2(NUM_SPRITES) + 2 * TILE_LOG2,
    parameter int          LVL_W       = $clog2(BAR_STEPS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_pix_valid,
    input  logic [9:0]               i_col,
    input  logic [9:0]               i_row,
    input  logic [NUM_SPRITES*6-1:0] i_spr_bcol,
    input  logic [NUM_SPRITES*6-1:0] i_spr_brow,
    input  logic [NUM_SPRITES-1:0]   i_spr_vis,
    output logic                     o_map_en,
    output logic [MAP_AW-1:0]        o_map_addr,
    input  logic [11:0]              i_map_data,
    output logic                     o_spr_en,
    output logic [SPR_AW-1:0]        o_spr_addr,
    input  logic [11:0]              i_spr_data,
    input  logic                     i_bar_start,
    output logic                     o_bar_busy,
    output logic [LVL_W-1:0]         o_bar_level,
    output logic [3:0]               o_red,
    output logic [3:0]               o_green,
    output logic [3:0]               o_blue
);
    localparam int SPR_IW = $clog2(NUM_SPRITES);

    logic [9:0]        bcol, brow;
    logic              spr_hit;
    logic [SPR_IW-1:0] spr_idx;
    logic              bar_pix;
    logic              s1_valid, s1_hit, s1_bar;
    rgb_t              pix_nxt, pix_q;

    assign bcol       = i_col >> TILE_LOG2;
    assign brow       = i_row >> TILE_LOG2;
    assign o_map_en   = i_pix_valid;
    assign o_map_addr = MAP_AW'(20'(bcol) * 20'(MAP_ROWS) + 20'(brow));

    // Scan from the top index down so the lowest-index hit is the last write.
    always_comb begin
        spr_hit = 1'b0;
        spr_idx = '0;
        for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
            if (i_spr_vis[k] && (bcol == 10'(i_spr_bcol[k*6 +: 6]))
                             && (brow == 10'(i_spr_brow[k*6 +: 6]))) begin
                spr_hit = 1'b1;
                spr_idx = SPR_IW'(k);
            end
        end
    end

    assign o_spr_en   = i_pix_valid && spr_hit;
    assign o_spr_addr = {spr_idx, i_row[TILE_LOG2-1:0], i_col[TILE_LOG2-1:0]};

`ifdef VGA_COMP_BAR_EN
    logic [15:0] bar_end;

    vga_bar_fsm #(
        .BAR_STEPS   (BAR_STEPS),
        .HOLD_FRAMES (HOLD_FRAMES),
        .LVL_W       (LVL_W)
    ) u_bar_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_valid (i_pix_valid),
        .col       (i_col),
        .row       (i_row),
        .bar_start (i_bar_start),
        .busy      (o_bar_busy),
        .level     (o_bar_level)
    );

    // The level register only moves on frame ticks, so it is already frame-latched.
    assign bar_end = 16'(BAR_X0) + 16'(o_bar_level) * 16'(BAR_STEP_W);
    assign bar_pix = ((i_row == 10'(BAR_ROW)) || (i_row == 10'(BAR_ROW + 1)))
                     && (16'(i_col) >= 16'(BAR_X0)) && (16'(i_col) < bar_end);
`else
    logic        unused_bar_start;
    logic [31:0] unused_bar_cfg;

    assign unused_bar_start = i_bar_start;
    assign unused_bar_cfg   = 32'(BAR_ROW + BAR_X0 + BAR_STEP_W + HOLD_FRAMES);
    assign o_bar_busy       = 1'b0;
    assign o_bar_level      = '0;
    assign bar_pix          = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_hit   <= 1'b0;
            s1_bar   <= 1'b0;
        end else begin
            s1_valid <= i_pix_valid;
            s1_hit   <= spr_hit;
            s1_bar   <= bar_pix;
        end
    end

    // A keyed sprite pixel falls through to the map, never to a lower sprite.
    always_comb begin
        pix_nxt = rgb_t'(i_map_data);
        if (s1_hit && (i_spr_data != TRANSP_KEY)) pix_nxt = rgb_t'(i_spr_data);
        if (s1_bar)                               pix_nxt = rgb_t'(BAR_COLOUR);
        if (!s1_valid)                            pix_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pix_q <= '0;
        else        pix_q <= pix_nxt;
    end

    assign o_red   = pix_q.r;
    assign o_green = pix_q.g;
    assign o_blue  = pix_q.b;

endmodule

// File: tb/tb_vga_tile_compositor.sv
// Randomised bench for vga_tile_compositor against a behavioural pixel/bar model.
// Follows VGA_COMP_BAR_EN so the same bench covers both builds.
module tb_vga_tile_compositor;
`ifdef VGA_COMP_BAR_EN
    localparam bit BAR_EN = 1'b1;
`else
    localparam bit BAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_pix_valid = 1'b0;
    logic [9:0]  i_col = '0, i_row = '0;
    logic [11:0] i_spr_bcol = '0, i_spr_brow = '0;
    logic [1:0]  i_spr_vis = '0;
    logic [11:0] i_map_data = '0, i_spr_data = '0;
    logic        i_bar_start = 1'b0;
    logic        o_map_en, o_spr_en, o_bar_busy;
    logic [10:0] o_map_addr;
    logic [8:0]  o_spr_addr;
    logic [3:0]  o_bar_level;
    logic [3:0]  o_red, o_green, o_blue;

    vga_tile_compositor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_pix_valid (i_pix_valid),
        .i_col       (i_col),
        .i_row       (i_row),
        .i_spr_bcol  (i_spr_bcol),
        .i_spr_brow  (i_spr_brow),
        .i_spr_vis   (i_spr_vis),
        .o_map_en    (o_map_en),
        .o_map_addr  (o_map_addr),
        .i_map_data  (i_map_data),
        .o_spr_en    (o_spr_en),
        .o_spr_addr  (o_spr_addr),
        .i_spr_data  (i_spr_data),
        .i_bar_start (i_bar_start),
        .o_bar_busy  (o_bar_busy),
        .o_bar_level (o_bar_level),
        .o_red       (o_red),
        .o_green     (o_green),
        .o_blue      (o_blue)
    );

    always #5 clk = ~clk;

    logic [11:0] map_mem [2048];
    logic [11:0] spr_mem [512];
    logic [11:0] hist [$];
    int          sb_col [2];
    int          sb_row [2];
    bit          s_vis  [2];
    bit          m_busy = 1'b0;
    int          m_n = 0;
    int          n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_level();
        if (!m_busy) return 0;
        return (m_n < 15) ? m_n : 15;
    endfunction

    function automatic int model_hit(int c, int r);
        int hit = -1;
        for (int k = 0; k < 2; k++)
            if (hit < 0 && s_vis[k] && sb_col[k] == c / 16 && sb_row[k] == r / 16) hit = k;
        return hit;
    endfunction

    function automatic logic [11:0] model_pix(bit v, int c, int r, int lvl);
        int          hit = model_hit(c, r);
        int          sa  = hit * 256 + (r % 16) * 16 + (c % 16);
        logic [11:0] px;
        if (!v) return 12'h000;
        px = map_mem[(c / 16) * 30 + r / 16];
        if (hit >= 0 && spr_mem[sa] != 12'hF0F) px = spr_mem[sa];
        if (BAR_EN && (r == 450 || r == 451) && c >= 20 && c < 20 + lvl * 40) px = 12'hF00;
        return px;
    endfunction

    task automatic set_sprites(input int c0, input int r0, input int c1, input int r1,
                               input logic [1:0] vis);
        sb_col[0] = c0; sb_row[0] = r0; sb_col[1] = c1; sb_row[1] = r1;
        s_vis[0] = vis[0]; s_vis[1] = vis[1];
        i_spr_bcol = {c1[5:0], c0[5:0]};
        i_spr_brow = {r1[5:0], r0[5:0]};
        i_spr_vis  = vis;
    endtask

    task automatic step(input bit v, input int c, input int r, input bit start);
        int          hit;
        logic [11:0] map_q, spr_q;
        @(negedge clk);
        if (hist.size() >= 2) chk("rgb", {20'd0, o_red, o_green, o_blue}, {20'd0, hist.pop_front()});
        chk("bar_level", {28'd0, o_bar_level}, m_level());
        chk("bar_busy", {31'd0, o_bar_busy}, {31'd0, m_busy});
        i_pix_valid = v;
        i_col       = c[9:0];
        i_row       = r[9:0];
        i_bar_start = start;
        #1;
        hit = model_hit(c, r);
        chk("map_en", {31'd0, o_map_en}, {31'd0, v});
        chk("map_addr", {21'd0, o_map_addr}, (c / 16) * 30 + r / 16);
        chk("spr_en", {31'd0, o_spr_en}, {31'd0, (v && hit >= 0)});
        if (v && hit >= 0) chk("spr_addr", {23'd0, o_spr_addr}, hit * 256 + (r % 16) * 16 + c % 16);
        hist.push_back(model_pix(v, c, r, m_level()));
        if (BAR_EN) begin
            if (!m_busy) begin
                if (start) begin m_busy = 1'b1; m_n = 0; end
            end else if (v && c == 0 && r == 0) begin
                m_n++;
                if (m_n == 75) m_busy = 1'b0;
            end
        end
        map_q = map_mem[o_map_addr];
        spr_q = o_spr_en ? spr_mem[o_spr_addr] : 12'($urandom);
        @(posedge clk);
        #1;
        i_map_data  = map_q;
        i_spr_data  = spr_q;
        i_bar_start = 1'b0;
    endtask

    task automatic tick();
        step(1'b1, 0, 0, 1'b0);
    endtask

    initial begin
        int c, r, k;
        for (int i = 0; i < 2048; i++) map_mem[i] = 12'($urandom);
        for (int i = 0; i < 512; i++) spr_mem[i] = ($urandom_range(0, 3) == 0) ? 12'hF0F : 12'($urandom);
        set_sprites(20, 20, 21, 21, 2'b00);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rgb", {20'd0, o_red, o_green, o_blue}, 32'd0);
        chk("rst_level", {28'd0, o_bar_level}, 32'd0);
        chk("rst_busy", {31'd0, o_bar_busy}, 32'd0);
        chk("rst_spr_en", {31'd0, o_spr_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hist.push_back(12'h000);
        hist.push_back(12'h000);

        // Sprite at (3,2): opaque, then keyed over map 0x123, then two overlapping.
        set_sprites(3, 2, 20, 20, 2'b01);
        spr_mem[82] = 12'h0A5;
        step(1'b1, 50, 37, 1'b0);
        map_mem[92] = 12'h123;
        spr_mem[82] = 12'hF0F;
        step(1'b1, 50, 37, 1'b0);
        spr_mem[82]  = 12'h0A5;
        spr_mem[338] = 12'h777;
        set_sprites(3, 2, 3, 2, 2'b11);
        step(1'b1, 50, 37, 1'b0);
        step(1'b0, 50, 37, 1'b0);
        step(1'b0, 300, 200, 1'b0);

        for (int i = 0; i < 300; i++) begin
            if (i % 25 == 0) begin
                c = $urandom_range(0, 39);
                r = $urandom_range(0, 29);
                if ($urandom_range(0, 2) == 0) set_sprites(c, r, c, r, 2'($urandom_range(0, 3)));
                else set_sprites(c, r, $urandom_range(0, 39), $urandom_range(0, 29), 2'($urandom_range(0, 3)));
            end
            k = $urandom_range(0, 1);
            if ($urandom_range(0, 2) != 0) begin
                c = sb_col[k] * 16 + $urandom_range(0, 15);
                r = sb_row[k] * 16 + $urandom_range(0, 15);
            end else begin
                c = $urandom_range(0, 639);
                r = $urandom_range(0, 479);
            end
            step($urandom_range(0, 5) != 0, c, r, 1'b0);
        end

        // Progress bar: fill, edge pixels, hold, ignored start, return to idle.
        set_sprites(30, 5, 31, 5, 2'b00);
        map_mem[8 * 30 + 28] = 12'h0F0;
        map_mem[1 * 30 + 28] = 12'h0F0;
        step(1'b1, 5, 5, 1'b1);
        repeat (3) tick();
        step(1'b1, 139, 450, 1'b0);
        step(1'b1, 140, 450, 1'b0);
        step(1'b1, 139, 451, 1'b0);
        step(1'b1, 19, 450, 1'b0);
        step(1'b1, 20, 451, 1'b0);
        step(1'b1, 100, 452, 1'b0);
        repeat (12) tick();
        step(1'b1, 7, 7, 1'b1);
        step(1'b1, 600, 450, 1'b0);
        repeat (60) tick();
        step(1'b1, 9, 9, 1'b0);
        step(1'b1, 9, 9, 1'b0);
        step(1'b1, 0, 0, 1'b1);
        step(1'b1, 3, 3, 1'b0);
        repeat (7) tick();
        repeat (3) step(1'b1, 100, 450, 1'b0);

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst_n       = 1'b0;
        i_pix_valid = 1'b0;
        #1;
        chk("arst_rgb", {20'd0, o_red, o_green, o_blue}, 32'd0);
        chk("arst_level", {28'd0, o_bar_level}, 32'd0);
        chk("arst_busy", {31'd0, o_bar_busy}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        m_busy = 1'b0;
        m_n    = 0;
        hist.delete();
        hist.push_back(12'h000);
        hist.push_back(12'h000);
        for (int i = 0; i < 30; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 639), $urandom_range(0, 479), 1'b0);
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
